// File: rtl/mul_div_controller_pkg.sv
// Shared types and constants for the multiply/divide controller,
// its interface and its divider datapath.
package mul_div_controller_pkg;

    localparam int CPU_DATA_WIDTH = 32;
    localparam int DIVIDE_STEPS   = 32;

    typedef enum logic [1:0] {
        OP_MULTIPLY  = 2'd0,
        OP_DIVIDE    = 2'd1,
        OP_MOVE_HIGH = 2'd2,
        OP_MOVE_LOW  = 2'd3
    } mul_div_operation_t;

    typedef enum logic [1:0] {
        IDLE,
        MULTIPLY,
        DIVIDE,
        DONE
    } mul_div_state_t;

    // Bundle handed over from the ID/EX register to the controller
    typedef struct packed {
        logic                      valid;
        mul_div_operation_t        operation;
        logic                      is_signed;
        logic [CPU_DATA_WIDTH-1:0] source1;
        logic [CPU_DATA_WIDTH-1:0] source2;
    } mul_div_request_t;

endpackage

// File: rtl/mul_div_controller_if.sv
// EX-stage <-> multiply/divide controller connection; the pipeline side is
// the master, the controller is the slave.
interface mul_div_controller_if;
    import mul_div_controller_pkg::*;

    logic                      request_valid;
    mul_div_operation_t        request_operation;
    logic                      request_signed;
    logic [CPU_DATA_WIDTH-1:0] source1;
    logic [CPU_DATA_WIDTH-1:0] source2;
    logic                      flush;
    logic                      stall;
    logic                      busy;
    logic [CPU_DATA_WIDTH-1:0] high_value;
    logic [CPU_DATA_WIDTH-1:0] low_value;

    modport master (
        output request_valid, request_operation, request_signed,
               source1, source2, flush,
        input  stall, busy, high_value, low_value
    );

    modport slave (
        input  request_valid, request_operation, request_signed,
               source1, source2, flush,
        output stall, busy, high_value, low_value
    );

endinterface

// File: rtl/mul_div_controller_divider.sv
// Unsigned restoring radix-2 divider: one quotient bit per step. The next_*
// outputs show the result of the step taken at the coming edge.
module mul_div_controller_divider
    import mul_div_controller_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      step,
    input  logic [CPU_DATA_WIDTH-1:0] dividend,
    input  logic [CPU_DATA_WIDTH-1:0] divisor,
    output logic [CPU_DATA_WIDTH-1:0] next_quotient,
    output logic [CPU_DATA_WIDTH-1:0] next_remainder
);

    localparam int W = CPU_DATA_WIDTH;

    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic [W-1:0] divisor_held;
    logic [W:0]   shifted;

    // The quotient register starts out holding the dividend and shifts its
    // bits into the remainder MSB-first as quotient bits shift in below.
    always_comb begin
        shifted        = {remainder, quotient[W-1]};
        next_quotient  = {quotient[W-2:0], 1'b0};
        next_remainder = shifted[W-1:0];
        if (shifted >= {1'b0, divisor_held}) begin
            next_quotient  = {quotient[W-2:0], 1'b1};
            next_remainder = W'(shifted - {1'b0, divisor_held});
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            quotient     <= '0;
            remainder    <= '0;
            divisor_held <= '0;
        end else if (start) begin
            quotient     <= dividend;
            remainder    <= '0;
            divisor_held <= divisor;
        end else if (step) begin
            quotient     <= next_quotient;
            remainder    <= next_remainder;
        end
    end

endmodule

// File: rtl/mul_div_controller.sv
// Multiply/divide sequencer for the EX stage: owns HI/LO, stalls EX while a
// multiply or divide runs, and commits only on a non-flushed DONE cycle.
module mul_div_controller
    import mul_div_controller_pkg::*;
#(
    parameter int MULTIPLY_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    mul_div_controller_if.slave  bus
);

    localparam int W = CPU_DATA_WIDTH;

    mul_div_state_t state, state_next;
    logic [4:0]     counter;
    logic [W-1:0]   high_reg, low_reg, staged_high, staged_low;
    logic [W-1:0]   operand_a, operand_b;
    logic           multiply_signed, commit_enable;
    logic           quotient_negate, remainder_negate;
    logic           accept, is_move, divider_start, divider_step;
    logic [W-1:0]   abs_source1, abs_source2, div_quotient, div_remainder;
    logic [2*W-1:0] extended_a, extended_b, product;

    assign accept  = bus.request_valid && !bus.flush;
    assign is_move = (bus.request_operation == OP_MOVE_HIGH) ||
                     (bus.request_operation == OP_MOVE_LOW);

    assign abs_source1 = (bus.request_signed && bus.source1[W-1]) ? -bus.source1 : bus.source1;
    assign abs_source2 = (bus.request_signed && bus.source2[W-1]) ? -bus.source2 : bus.source2;

    // Sign-extending to the full product width keeps the low 64 bits exact
    assign extended_a = {{W{multiply_signed & operand_a[W-1]}}, operand_a};
    assign extended_b = {{W{multiply_signed & operand_b[W-1]}}, operand_b};
    assign product    = extended_a * extended_b;

    assign bus.stall      = accept && (state != DONE) && !((state == IDLE) && is_move);
    assign bus.busy       = (state != IDLE);
    assign bus.high_value = high_reg;
    assign bus.low_value  = low_reg;

    mul_div_controller_divider divider (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (divider_start),
        .step           (divider_step),
        .dividend       (abs_source1),
        .divisor        (abs_source2),
        .next_quotient  (div_quotient),
        .next_remainder (div_remainder)
    );

    always_comb begin
        state_next    = state;
        divider_start = 1'b0;
        divider_step  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && bus.request_operation == OP_MULTIPLY) begin
                    state_next = MULTIPLY;
                end else if (accept && bus.request_operation == OP_DIVIDE) begin
                    state_next    = (bus.source2 == '0) ? DONE : DIVIDE;
                    divider_start = (bus.source2 != '0);
                end
            end
            MULTIPLY: if (counter == '0) state_next = DONE;
            DIVIDE: begin
                divider_step = 1'b1;
                if (counter == 5'(DIVIDE_STEPS - 1)) state_next = DONE;
            end
            DONE: state_next = IDLE;
        endcase
        if (bus.flush) state_next = IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= IDLE;
            counter          <= '0;
            high_reg         <= '0;
            low_reg          <= '0;
            staged_high      <= '0;
            staged_low       <= '0;
            operand_a        <= '0;
            operand_b        <= '0;
            multiply_signed  <= 1'b0;
            commit_enable    <= 1'b0;
            quotient_negate  <= 1'b0;
            remainder_negate <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (accept) begin
                    case (bus.request_operation)
                        OP_MOVE_HIGH: high_reg <= bus.source1;
                        OP_MOVE_LOW:  low_reg  <= bus.source1;
                        OP_MULTIPLY: begin
                            operand_a       <= bus.source1;
                            operand_b       <= bus.source2;
                            multiply_signed <= bus.request_signed;
                            counter         <= 5'(MULTIPLY_LATENCY - 1);
                            commit_enable   <= 1'b1;
                        end
                        OP_DIVIDE: begin
                            counter          <= '0;
                            commit_enable    <= (bus.source2 != '0);
                            quotient_negate  <= bus.request_signed & (bus.source1[W-1] ^ bus.source2[W-1]);
                            remainder_negate <= bus.request_signed & bus.source1[W-1];
                        end
                    endcase
                end
                MULTIPLY: begin
                    {staged_high, staged_low} <= product;
                    if (counter != '0) counter <= counter - 5'd1;
                end
                DIVIDE: begin
                    counter <= counter + 5'd1;
                    if (counter == 5'(DIVIDE_STEPS - 1)) begin
                        staged_low  <= quotient_negate  ? -div_quotient  : div_quotient;
                        staged_high <= remainder_negate ? -div_remainder : div_remainder;
                    end
                end
                DONE: if (!bus.flush && commit_enable) begin
                    high_reg <= staged_high;
                    low_reg  <= staged_low;
                end
            endcase
        end
    end

    // EX must keep presenting the instruction until it is released or flushed
    request_held: assert property (@(posedge clock) disable iff (!reset_n)
        ((state == MULTIPLY) || (state == DIVIDE)) && !bus.flush |-> bus.request_valid);

endmodule

// File: tb/tb_mul_div_controller.sv
// Self-checking bench for mul_div_controller: directed scenarios plus random
// operations compared against an arithmetic model of HI/LO and stall length.
module tb_mul_div_controller;
    import mul_div_controller_pkg::*;

    localparam int MUL_LAT = 1;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    int          total_checks  = 0;
    int          passed_checks = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mul_div_controller_if bus_if ();

    mul_div_controller #(.MULTIPLY_LATENCY(MUL_LAT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clock = ~clock;

    // Every comparison goes through here so the counts stay honest
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        if (observed === expected) passed_checks++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Reference behaviour: plain 64-bit arithmetic, truncating division
    task automatic modelApply(input mul_div_operation_t op, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MOVE_HIGH: model_hi = a;
            OP_MOVE_LOW:  model_lo = a;
            OP_MULTIPLY: begin
                up = sgn ? longint'(sa * sb) : ua * ub;
                model_hi = up[63:32];
                model_lo = up[31:0];
            end
            OP_DIVIDE: if (b != 0) begin
                if (sgn) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    model_lo = 32'(sq);
                    model_hi = 32'(sr);
                end else begin
                    model_lo = a / b;
                    model_hi = a % b;
                end
            end
        endcase
    endtask

    function automatic int expectedStall(input mul_div_operation_t op, input logic [31:0] b);
        case (op)
            OP_MULTIPLY: return 1 + MUL_LAT;
            OP_DIVIDE:   return (b == 0) ? 1 : DIVIDE_STEPS + 1;
            default:     return 0;
        endcase
    endfunction

    // Called at a negedge. flush_at: 0 = never, k>0 = raise flush in request
    // cycle k, -1 = raise flush in the first cycle that does not stall.
    // Returns at a negedge with request_valid and flush low again.
    task automatic applyStimulus(input mul_div_operation_t op, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input int flush_at, output int stall_cycles, output bit flushed);
        bit released = 1'b0;
        stall_cycles = 0;
        flushed      = 1'b0;
        bus_if.request_valid     = 1'b1;
        bus_if.request_operation = op;
        bus_if.request_signed    = sgn;
        bus_if.source1           = a;
        bus_if.source2           = b;
        for (int c = 1; c <= 100; c++) begin
            if (flush_at == c) begin
                checkOutput("busy_before_flush", {63'd0, bus_if.busy}, {63'd0, (c > 1)});
                bus_if.flush = 1'b1;
                flushed      = 1'b1;
            end
            #1;
            if (!bus_if.stall && flush_at == -1 && !flushed) begin
                bus_if.flush = 1'b1;
                flushed      = 1'b1;
                #1;
            end
            if (!bus_if.stall) begin
                released = 1'b1;
                break;
            end
            stall_cycles++;
            @(negedge clock);
        end
        if (!released) checkOutput("stall_release_timeout", 64'd0, 64'd1);
        @(negedge clock);
        bus_if.request_valid = 1'b0;
        bus_if.flush         = 1'b0;
        if (!flushed) modelApply(op, sgn, a, b);
    endtask

    task automatic runOp(input string tag, input mul_div_operation_t op, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b);
        int stalls;
        bit fl;
        applyStimulus(op, sgn, a, b, 0, stalls, fl);
        checkOutput({tag, "_stall"}, 64'(stalls), 64'(expectedStall(op, b)));
        checkOutput({tag, "_hi"}, {32'd0, bus_if.high_value}, {32'd0, model_hi});
        checkOutput({tag, "_lo"}, {32'd0, bus_if.low_value}, {32'd0, model_lo});
        checkOutput({tag, "_busy"}, {63'd0, bus_if.busy}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          stalls;
        bit          fl;
        int          op_index;
        logic [31:0] ra, rb;
        logic        rs;

        bus_if.request_valid     = 1'b0;
        bus_if.request_operation = OP_MULTIPLY;
        bus_if.request_signed    = 1'b0;
        bus_if.source1           = '0;
        bus_if.source2           = '0;
        bus_if.flush             = 1'b0;

        // Reset values
        repeat (3) @(negedge clock);
        checkOutput("reset_stall", {63'd0, bus_if.stall}, 64'd0);
        checkOutput("reset_busy", {63'd0, bus_if.busy}, 64'd0);
        checkOutput("reset_hi", {32'd0, bus_if.high_value}, 64'd0);
        checkOutput("reset_lo", {32'd0, bus_if.low_value}, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        runOp("mul_signed", OP_MULTIPLY, 1'b1, 32'hFFFFFFFE, 32'h00000003);
        checkOutput("mul_signed_hi_const", {32'd0, bus_if.high_value}, 64'hFFFFFFFF);
        checkOutput("mul_signed_lo_const", {32'd0, bus_if.low_value}, 64'hFFFFFFFA);

        runOp("div_unsigned", OP_DIVIDE, 1'b0, 32'd100, 32'd7);
        checkOutput("div_unsigned_lo_const", {32'd0, bus_if.low_value}, 64'd14);
        runOp("div_signed", OP_DIVIDE, 1'b1, 32'hFFFFFF9C, 32'd7);
        checkOutput("div_signed_lo_const", {32'd0, bus_if.low_value}, 64'hFFFFFFF2);
        checkOutput("div_signed_hi_const", {32'd0, bus_if.high_value}, 64'hFFFFFFFE);
        runOp("div_overflow", OP_DIVIDE, 1'b1, 32'h80000000, 32'hFFFFFFFF);

        // Divide by zero leaves the preloaded HI/LO alone
        runOp("move_high", OP_MOVE_HIGH, 1'b0, 32'h12345678, 32'd0);
        runOp("move_low", OP_MOVE_LOW, 1'b0, 32'h12345678, 32'd0);
        runOp("div_zero", OP_DIVIDE, 1'b1, 32'hDEADBEEF, 32'd0);
        checkOutput("div_zero_hi_const", {32'd0, bus_if.high_value}, 64'h12345678);

        // Flush at divide step 10 (request cycle 12), then a new request at once
        applyStimulus(OP_DIVIDE, 1'b0, 32'd1000, 32'd3, 12, stalls, fl);
        checkOutput("flush_div_busy", {63'd0, bus_if.busy}, 64'd0);
        checkOutput("flush_div_hi", {32'd0, bus_if.high_value}, {32'd0, model_hi});
        checkOutput("flush_div_lo", {32'd0, bus_if.low_value}, {32'd0, model_lo});
        runOp("after_flush_div", OP_MULTIPLY, 1'b0, 32'd12, 32'd13);

        // Flush landing on the DONE cycle discards the staged product
        applyStimulus(OP_MULTIPLY, 1'b1, 32'd7, 32'd9, -1, stalls, fl);
        checkOutput("flush_done_stall", 64'(stalls), 64'(1 + MUL_LAT));
        checkOutput("flush_done_busy", {63'd0, bus_if.busy}, 64'd0);
        checkOutput("flush_done_hi", {32'd0, bus_if.high_value}, {32'd0, model_hi});
        checkOutput("flush_done_lo", {32'd0, bus_if.low_value}, {32'd0, model_lo});
        runOp("after_flush_done", OP_DIVIDE, 1'b0, 32'd50, 32'd6);

        // Back-to-back move then unsigned multiply
        runOp("b2b_move_low", OP_MOVE_LOW, 1'b0, 32'hA5A5A5A5, 32'd0);
        runOp("b2b_mul", OP_MULTIPLY, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkOutput("b2b_mul_lo_const", {32'd0, bus_if.low_value}, 64'h00000001);
        checkOutput("b2b_mul_hi_const", {32'd0, bus_if.high_value}, 64'hFFFFFFFE);

        // Reset during divide step 20 (request cycle 22)
        bus_if.request_valid     = 1'b1;
        bus_if.request_operation = OP_DIVIDE;
        bus_if.request_signed    = 1'b0;
        bus_if.source1           = 32'd99999;
        bus_if.source2           = 32'd17;
        repeat (21) @(negedge clock);
        checkOutput("pre_reset_busy", {63'd0, bus_if.busy}, 64'd1);
        reset_n              = 1'b0;
        bus_if.request_valid = 1'b0;
        @(negedge clock);
        model_hi = '0;
        model_lo = '0;
        checkOutput("midreset_stall", {63'd0, bus_if.stall}, 64'd0);
        checkOutput("midreset_busy", {63'd0, bus_if.busy}, 64'd0);
        checkOutput("midreset_hi", {32'd0, bus_if.high_value}, 64'd0);
        checkOutput("midreset_lo", {32'd0, bus_if.low_value}, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        runOp("post_reset_div", OP_DIVIDE, 1'b0, 32'd99999, 32'd17);

        // Random operations against the model
        for (int i = 0; i < 24; i++) begin
            op_index = int'($urandom_range(0, 3));
            rs       = 1'($urandom_range(0, 1));
            ra       = $urandom;
            rb       = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
            runOp($sformatf("rand%0d", i), mul_div_operation_t'(op_index[1:0]), rs, ra, rb);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
